coax_tx_ctrl: RTL and testbench

COAX_TX_CTRL -- requirements
Module: coax_tx_ctrl

---
 rtl/coax_pkg.sv | 23 ++
 rtl/coax_tx_ctrl_timer.sv | 27 ++
 rtl/coax_tx_ctrl.sv | 174 +++++++++++++++++
 tb/tb_coax_tx_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coax_pkg.sv
// Shared types and widths for the coax transmit controller.
// Optional feature macro used by this slice: COAX_TX_CTRL_ABORT_EN.
package coax_pkg;

  localparam int unsigned WORD_W  = 10;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned LEN_W   = 6;
  localparam int unsigned MAX_LEN = 32;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_WAIT_READY = 3'd2,
    S_DRAIN      = 3'd3,
    S_GAP        = 3'd4
  } state_t;

  // Requested lengths beyond the buffer depth are served as a full buffer.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/coax_tx_ctrl_timer.sv
// Loadable down-counter shared by the GAP interval and the ready/drain timeouts.
// Load wins over counting; the count parks at zero.
module coax_tx_ctrl_timer #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/coax_tx_ctrl.sv
// Frame sequencer: reads words from an external buffer and hands them to coax_tx.
// Build option: define COAX_TX_CTRL_ABORT_EN to add the abort input.
module coax_tx_ctrl
  import coax_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef COAX_TX_CTRL_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [WORD_W-1:0] buf_data,
  output logic [WORD_W-1:0] coax_data,
  output logic              coax_load,
  input  logic              coax_ready,
  input  logic              coax_active,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned TMR_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  // Timer is loaded with N-1 so that the zero cycle is the Nth cycle in the state.
  localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);

  state_t              r_state, w_state_nxt;
  logic [LEN_W-1:0]    r_len, w_len_nxt;
  logic [LEN_W-1:0]    r_idx, w_idx_nxt, w_idx_inc;
  logic [ADDR_W-1:0]   r_buf_addr, w_addr_nxt;
  logic [WORD_W-1:0]   r_coax_data, w_data_nxt;
  logic                r_done, w_done_nxt;
  logic                r_error, w_error_nxt;
  logic                w_load;
  logic                w_tmr_load;
  logic [TMR_W-1:0]    w_tmr_val;
  logic                w_tmr_zero;
  logic                w_abort;

`ifdef COAX_TX_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_idx_inc = r_idx + 1'b1;

  coax_tx_ctrl_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_addr_nxt  = r_buf_addr;
    w_data_nxt  = r_coax_data;
    w_done_nxt  = 1'b0;
    w_error_nxt = 1'b0;
    w_load      = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = TO_LOAD;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_len_nxt   = clamp_len(length);
            w_idx_nxt   = '0;
            w_addr_nxt  = '0;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        w_data_nxt  = buf_data;
        w_tmr_load  = 1'b1;
        w_tmr_val   = TO_LOAD;
        w_state_nxt = S_WAIT_READY;
      end
      S_WAIT_READY: begin
        if (coax_ready) begin
          w_load    = 1'b1;
          w_idx_nxt = w_idx_inc;
          if (w_idx_inc == r_len) begin
            w_tmr_load  = 1'b1;
            w_tmr_val   = TO_LOAD;
            w_state_nxt = S_DRAIN;
          end else begin
            w_addr_nxt  = w_idx_inc[ADDR_W-1:0];
            w_state_nxt = S_FETCH;
          end
        end else if (w_tmr_zero) begin
          w_error_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!coax_active) begin
          w_tmr_load  = 1'b1;
          w_tmr_val   = GAP_LOAD;
          w_state_nxt = S_GAP;
        end else if (w_tmr_zero) begin
          w_error_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (w_tmr_zero) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort overrides everything decided above, including a same-cycle load.
    if (w_abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_load      = 1'b0;
      w_done_nxt  = 1'b0;
      w_error_nxt = 1'b1;
      w_tmr_load  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len       <= '0;
      r_idx       <= '0;
      r_buf_addr  <= '0;
      r_coax_data <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_len       <= w_len_nxt;
      r_idx       <= w_idx_nxt;
      r_buf_addr  <= w_addr_nxt;
      r_coax_data <= w_data_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign buf_addr  = r_buf_addr;
  assign coax_data = r_coax_data;
  assign coax_load = w_load;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_coax_tx_ctrl.sv
// Directed bench for coax_tx_ctrl; the abort scenario is built when
// COAX_TX_CTRL_ABORT_EN is defined.
module tb_coax_tx_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] length = '0;
  logic       coax_ready = 1'b0;
  logic       coax_active = 1'b0;
  logic [4:0] buf_addr;
  logic [9:0] buf_data;
  logic [9:0] coax_data;
  logic       coax_load;
  logic       busy;
  logic       done;
  logic       error;
`ifdef COAX_TX_CTRL_ABORT_EN
  logic       abort = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int   n_loads = 0;
  int   n_done = 0;
  int   n_err = 0;
  int   n_consec = 0;
  int   n_both = 0;
  logic r_prev_load = 1'b0;
  logic [9:0] q_data[$];
  logic [4:0] q_addr[$];

  always #5 clk = ~clk;

  // Buffer content: each word encodes its own address.
  function automatic logic [9:0] word_of(input logic [4:0] a);
    return {a, a ^ 5'h15};
  endfunction

  assign buf_data = word_of(buf_addr);

  coax_tx_ctrl #(
    .GAP_CYCLES     (16),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
`ifdef COAX_TX_CTRL_ABORT_EN
    .abort       (abort),
`endif
    .start       (start),
    .length      (length),
    .buf_addr    (buf_addr),
    .buf_data    (buf_data),
    .coax_data   (coax_data),
    .coax_load   (coax_load),
    .coax_ready  (coax_ready),
    .coax_active (coax_active),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always @(negedge clk) begin
    if (coax_load) begin
      n_loads <= n_loads + 1;
      q_data.push_back(coax_data);
      q_addr.push_back(buf_addr);
    end
    if (coax_load && r_prev_load) n_consec <= n_consec + 1;
    if (done && error) n_both <= n_both + 1;
    if (done) n_done <= n_done + 1;
    if (error) n_err <= n_err + 1;
    r_prev_load <= coax_load;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_error"}, int'(error), 0);
    check({tag, "_load"}, int'(coax_load), 0);
    check({tag, "_addr"}, int'(buf_addr), 0);
    check({tag, "_data"}, int'(coax_data), 0);
  endtask

  initial begin
    int n;
    int cnt;
    int bad;
    int b_loads;
    int b_done;
    int b_err;

    // Reset state
    @(posedge clk);
    #1;
    check_all_zero("rst");

    // Length 3, start on the first edge after reset release
    @(negedge clk);
    reset_n = 1'b1;
    start = 1'b1;
    length = 6'd3;
    coax_ready = 1'b1;
    b_loads = n_loads; b_done = n_done;
    cyc(1);
    start = 1'b0;
    check("t1_busy", int'(busy), 1);
    n = 0;
    while (!coax_load && n < 10) begin cyc(1); n++; end
    check("t1_first_load_lat", n, 1);
    coax_active = 1'b1;
    cyc(20);
    coax_active = 1'b0;
    n = 0;
    while (!done && n < 40) begin cyc(1); n++; end
    // One edge to sample coax_active low, then 16 GAP cycles.
    check("t1_done_lat", n, 17);
    cyc(1);
    check("t1_done_pulse", int'(done), 0);
    check("t1_busy_end", int'(busy), 0);
    check("t1_loads", n_loads - b_loads, 3);
    check("t1_dones", n_done - b_done, 1);
    for (int i = 0; i < 3; i++)
      check($sformatf("t1_word%0d", i), int'(q_data[b_loads + i]), int'(word_of(5'(i))));

    // Length 0
    b_loads = n_loads; b_done = n_done;
    start = 1'b1;
    length = 6'd0;
    cyc(1);
    start = 1'b0;
    check("t2_done", int'(done), 1);
    check("t2_busy", int'(busy), 0);
    cyc(1);
    check("t2_done_pulse", int'(done), 0);
    check("t2_busy2", int'(busy), 0);
    check("t2_loads", n_loads - b_loads, 0);
    check("t2_dones", n_done - b_done, 1);

    // Ready timeout
    coax_ready = 1'b0;
    b_loads = n_loads; b_done = n_done; b_err = n_err;
    start = 1'b1;
    length = 6'd2;
    cyc(1);
    start = 1'b0;
    n = 1;
    while (!error && n < 1100) begin cyc(1); n++; end
    // WAIT_READY entered at n=2, error 1024 edges later.
    check("t3_err_lat", n, 1026);
    check("t3_busy", int'(busy), 0);
    cyc(1);
    check("t3_err_pulse", int'(error), 0);
    check("t3_loads", n_loads - b_loads, 0);
    check("t3_dones", n_done - b_done, 0);
    check("t3_errs", n_err - b_err, 1);

    // Full buffer with start pulses while busy
    coax_ready = 1'b1;
    coax_active = 1'b0;
    b_loads = n_loads; b_done = n_done;
    start = 1'b1;
    length = 6'd32;
    cyc(1);
    n = 0;
    while (!done && n < 200) begin
      start = ((n % 7) == 3);
      length = 6'd5;
      cyc(1);
      n++;
    end
    start = 1'b0;
    check("t4_done_seen", int'(done), 1);
    cyc(20);
    check("t4_loads", n_loads - b_loads, 32);
    check("t4_dones", n_done - b_done, 1);
    check("t4_busy", int'(busy), 0);
    check("t4_addr_hold", int'(buf_addr), 31);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (q_addr[b_loads + i] !== 5'(i)) bad++;
      if (q_data[b_loads + i] !== word_of(5'(i))) bad++;
    end
    check("t4_order", bad, 0);

    // Length above 32 is clamped
    b_loads = n_loads; b_done = n_done;
    start = 1'b1;
    length = 6'd45;
    cyc(1);
    start = 1'b0;
    n = 0;
    while (!done && n < 200) begin cyc(1); n++; end
    cyc(2);
    check("t5_loads", n_loads - b_loads, 32);
    check("t5_dones", n_done - b_done, 1);

    // Reset after the second of four loads
    coax_active = 1'b1;
    b_loads = n_loads;
    start = 1'b1;
    length = 6'd4;
    cyc(1);
    start = 1'b0;
    cnt = 0;
    n = 0;
    while (cnt < 2 && n < 20) begin
      cyc(1);
      n++;
      if (coax_load) cnt++;
    end
    check("t6_two_loads", cnt, 2);
    cyc(1);
    reset_n = 1'b0;
    #1;
    check_all_zero("t6");
    b_done = n_done; b_err = n_err;
    cyc(3);
    reset_n = 1'b1;
    coax_active = 1'b0;
    cyc(40);
    check("t6_dones", n_done - b_done, 0);
    check("t6_errs", n_err - b_err, 0);
    check("t6_loads", n_loads - b_loads, 2);
    check("t6_busy", int'(busy), 0);

`ifdef COAX_TX_CTRL_ABORT_EN
    // Abort while draining
    coax_active = 1'b1;
    b_loads = n_loads; b_done = n_done; b_err = n_err;
    start = 1'b1;
    length = 6'd3;
    cyc(1);
    start = 1'b0;
    cnt = 0;
    n = 0;
    while (cnt < 3 && n < 20) begin
      cyc(1);
      n++;
      if (coax_load) cnt++;
    end
    cyc(1);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check("t7_error", int'(error), 1);
    check("t7_busy", int'(busy), 0);
    check("t7_done", int'(done), 0);
    coax_active = 1'b0;
    cyc(20);
    check("t7_dones", n_done - b_done, 0);
    check("t7_errs", n_err - b_err, 1);
    check("t7_loads", n_loads - b_loads, 3);
`endif

    check("no_consec_loads", n_consec, 0);
    check("no_done_with_error", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
